// File: rtl/result_trace_buffer_if.sv
// Capture-side and display-side signal bundle for result_trace_buffer.
// DEPTH must match the DEPTH of the attached result_trace_buffer.
interface result_trace_buffer_if #(
    parameter int unsigned DEPTH = 16
);
    logic                     sample_en;
    logic [31:0]              result1;
    logic                     valid1;
    logic [31:0]              result2;
    logic                     valid2;
    logic                     btn;
    logic [7:0]               display_byte;
    logic                     view_mode;
    logic [$clog2(DEPTH)-1:0] view_offset;
    logic [$clog2(DEPTH):0]   entry_count;
    logic                     overflow;

    modport master (
        output sample_en, result1, valid1, result2, valid2, btn,
        input  display_byte, view_mode, view_offset, entry_count, overflow
    );

    modport slave (
        input  sample_en, result1, valid1, result2, valid2, btn,
        output display_byte, view_mode, view_offset, entry_count, overflow
    );
endinterface

// File: rtl/result_trace_buffer.sv
// ALU result history ring with debounced-button browsing for the 7-seg display.
// Optional: define TRACE_SKIP_ZERO_EN to drop valid results equal to zero.
module result_trace_buffer #(
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned TIMEOUT_CYCLES  = 500_000_000
) (
    input  logic                 clk,
    input  logic                 n_rst,
    result_trace_buffer_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned OW = AW + 2;
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        LIVE   = 1'b0,
        BROWSE = 1'b1
    } state_t;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic [7:0]    r_disp;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [DW-1:0] r_db_cnt;
    logic          r_press;

    state_t        r_state;
    logic [AW-1:0] r_offset;
    logic [TW-1:0] r_tmo;

    logic          w_v1;
    logic          w_v2;
    logic [1:0]    w_n;
    logic [AW-1:0] w_idx2;
    logic [OW-1:0] w_cnt_sum;
    logic          w_wrap;
    logic [CW-1:0] w_cnt_next;
    logic [OW-1:0] w_off_sum;
    logic          w_off_past;
    logic [AW-1:0] w_show_idx;

`ifdef TRACE_SKIP_ZERO_EN
    assign w_v1 = bus.sample_en && bus.valid1 && (bus.result1 != '0);
    assign w_v2 = bus.sample_en && bus.valid2 && (bus.result2 != '0);
`else
    assign w_v1 = bus.sample_en && bus.valid1;
    assign w_v2 = bus.sample_en && bus.valid2;
`endif

    assign w_n        = {1'b0, w_v1} + {1'b0, w_v2};
    // result2 follows result1 only when result1 was actually written
    assign w_idx2     = r_wr_ptr + AW'(w_v1);
    assign w_cnt_sum  = OW'(r_count) + OW'(w_n);
    assign w_wrap     = w_cnt_sum > OW'(DEPTH);
    assign w_cnt_next = w_wrap ? CW'(DEPTH) : w_cnt_sum[CW-1:0];

    // Pinned offset compared against the post-capture count at full width
    assign w_off_sum  = OW'(r_offset) + OW'(w_n) + OW'(r_press);
    assign w_off_past = w_off_sum >= OW'(w_cnt_next);
    assign w_show_idx = r_wr_ptr - AW'(1) - r_offset;

    always_ff @(posedge clk) begin
        if (w_v1) r_mem[r_wr_ptr] <= bus.result1;
        if (w_v2) r_mem[w_idx2]   <= bus.result2;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_disp     <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_n);
            r_count  <= w_cnt_next;
            if (w_wrap) r_overflow <= 1'b1;
            r_disp   <= (r_count == '0) ? 8'h00 : r_mem[w_show_idx][7:0];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_level  <= 1'b0;
            r_db_cnt <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync1 <= bus.btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_level  <= r_sync2;
                r_db_cnt <= '0;
                r_press  <= r_sync2;
            end else begin
                r_db_cnt <= r_db_cnt + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= LIVE;
            r_offset <= '0;
            r_tmo    <= '0;
        end else begin
            case (r_state)
                LIVE: begin
                    r_offset <= '0;
                    r_tmo    <= '0;
                    if (r_press && (r_count >= CW'(2))) begin
                        r_state  <= BROWSE;
                        r_offset <= AW'(1);
                    end
                end
                BROWSE: begin
                    if (w_off_past) begin
                        r_state  <= LIVE;
                        r_offset <= '0;
                        r_tmo    <= '0;
                    end else if (r_press) begin
                        r_offset <= w_off_sum[AW-1:0];
                        r_tmo    <= '0;
                    end else if (r_tmo == TMO_LAST) begin
                        r_state  <= LIVE;
                        r_offset <= '0;
                        r_tmo    <= '0;
                    end else begin
                        r_offset <= w_off_sum[AW-1:0];
                        r_tmo    <= r_tmo + TW'(1);
                    end
                end
                default: begin
                    r_state  <= LIVE;
                    r_offset <= '0;
                    r_tmo    <= '0;
                end
            endcase
        end
    end

    assign bus.display_byte = r_disp;
    assign bus.view_mode    = (r_state == BROWSE);
    assign bus.view_offset  = r_offset;
    assign bus.entry_count  = r_count;
    assign bus.overflow     = r_overflow;
endmodule

// File: tb/tb_result_trace_buffer.sv
// Bench for result_trace_buffer: vector table, directed browse sequences,
// and randomized traffic against a queue-based history model.
module tb_result_trace_buffer;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DEB   = 4;
    localparam int unsigned TMO   = 100;
`ifdef TRACE_SKIP_ZERO_EN
    localparam int EXP6 = 1;
`else
    localparam int EXP6 = 2;
`endif

    logic clk   = 1'b0;
    logic n_rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    result_trace_buffer_if #(.DEPTH(DEPTH)) bus ();

    result_trace_buffer #(
        .DEPTH(DEPTH),
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: history as a queue (oldest at front)
    logic [31:0] m_hist[$];
    bit          m_bq[$];
    bit          m_mode, m_ovf, m_lvl, m_press_p;
    int          m_off, m_tmo, m_run;
    logic [7:0]  m_disp;

    typedef struct {
        bit          se;
        bit          v1;
        logic [31:0] r1;
        bit          v2;
        logic [31:0] r2;
        int          e_cnt;
        logic [7:0]  e_disp;
        bit          e_ovf;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        m_bq.delete();
        m_bq.push_back(1'b0);
        m_bq.push_back(1'b0);
        m_mode = 0; m_ovf = 0; m_lvl = 0; m_press_p = 0;
        m_off = 0; m_tmo = 0; m_run = 0; m_disp = 8'h00;
    endtask

    task automatic model_edge();
        logic [7:0]  d_next;
        logic [31:0] w;
        bit          press, e1, e2, s;
        int          n, oldc, newc, noff;
        if (m_hist.size() == 0) d_next = 8'h00;
        else begin
            w = m_hist[m_hist.size() - 1 - m_off];
            d_next = w[7:0];
        end
        press = m_press_p;
        m_press_p = 0;
        e1 = bus.sample_en && bus.valid1;
        e2 = bus.sample_en && bus.valid2;
`ifdef TRACE_SKIP_ZERO_EN
        if (bus.result1 == 32'h0) e1 = 0;
        if (bus.result2 == 32'h0) e2 = 0;
`endif
        n = int'(e1) + int'(e2);
        oldc = m_hist.size();
        if (oldc + n > int'(DEPTH)) m_ovf = 1;
        if (e1) m_hist.push_back(bus.result1);
        if (e2) m_hist.push_back(bus.result2);
        while (m_hist.size() > DEPTH) void'(m_hist.pop_front());
        newc = m_hist.size();
        if (!m_mode) begin
            if (press && oldc >= 2) begin
                m_mode = 1; m_off = 1; m_tmo = 0;
            end
        end else begin
            noff = m_off + n + int'(press);
            if (noff >= newc) begin
                m_mode = 0; m_off = 0; m_tmo = 0;
            end else if (press) begin
                m_off = noff; m_tmo = 0;
            end else if (m_tmo == int'(TMO) - 1) begin
                m_mode = 0; m_off = 0; m_tmo = 0;
            end else begin
                m_off = noff; m_tmo++;
            end
        end
        m_disp = d_next;
        s = m_bq.pop_front();
        m_bq.push_back(bus.btn);
        if (s != m_lvl) begin
            m_run++;
            if (m_run == int'(DEB)) begin
                m_lvl = s; m_run = 0; m_press_p = s;
            end
        end else m_run = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        chk("mdl_disp", 32'(bus.display_byte), 32'(m_disp));
        chk("mdl_cnt",  32'(bus.entry_count),  32'(m_hist.size()));
        chk("mdl_mode", 32'(bus.view_mode),    32'(m_mode));
        chk("mdl_off",  32'(bus.view_offset),  32'(m_off));
        chk("mdl_ovf",  32'(bus.overflow),     32'(m_ovf));
    endtask

    task automatic idle_in();
        bus.sample_en = 0; bus.valid1 = 0; bus.valid2 = 0;
        bus.result1 = '0; bus.result2 = '0;
    endtask

    task automatic reset_mid();
        idle_in();
        bus.btn = 0;
        n_rst = 0;
        #1;
        chk("rst_disp", 32'(bus.display_byte), 32'h0);
        chk("rst_cnt",  32'(bus.entry_count),  32'h0);
        chk("rst_mode", 32'(bus.view_mode),    32'h0);
        chk("rst_off",  32'(bus.view_offset),  32'h0);
        chk("rst_ovf",  32'(bus.overflow),     32'h0);
        #1;
        n_rst = 1;
        model_reset();
    endtask

    task automatic press_seq();
        for (int i = 1; i <= 16; i++) begin
            bus.btn = (i <= 8);
            step();
        end
    endtask

    task automatic strobe(input bit v1, input logic [31:0] r1, input bit v2, input logic [31:0] r2);
        bus.sample_en = 1; bus.valid1 = v1; bus.result1 = r1;
        bus.valid2 = v2; bus.result2 = r2;
        step();
        idle_in();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int hold;
        bit btn_r;
        idle_in();
        bus.btn = 0;
        #3;
        reset_mid();
        #17;

        tbl[0] = '{0, 0, 32'h0,  0, 32'h0,  0, 8'h00, 0};
        tbl[1] = '{1, 1, 32'h12, 0, 32'h0,  1, 8'h00, 0};
        tbl[2] = '{0, 0, 32'h0,  0, 32'h0,  1, 8'h12, 0};
        tbl[3] = '{1, 1, 32'h01, 1, 32'h02, 3, 8'h12, 0};
        tbl[4] = '{1, 1, 32'h03, 1, 32'h04, 4, 8'h02, 1};
        tbl[5] = '{1, 1, 32'h05, 1, 32'h06, 4, 8'h04, 1};
        tbl[6] = '{0, 1, 32'hEE, 1, 32'hFF, 4, 8'h06, 1};
        for (int i = 0; i < 7; i++) begin
            bus.sample_en = tbl[i].se;
            bus.valid1 = tbl[i].v1; bus.result1 = tbl[i].r1;
            bus.valid2 = tbl[i].v2; bus.result2 = tbl[i].r2;
            step();
            chk("tbl_cnt",  32'(bus.entry_count),  32'(tbl[i].e_cnt));
            chk("tbl_disp", 32'(bus.display_byte), 32'(tbl[i].e_disp));
            chk("tbl_ovf",  32'(bus.overflow),     32'(tbl[i].e_ovf));
        end
        idle_in();

        // Short glitch must not register as a press
        bus.btn = 1;
        repeat (3) step();
        bus.btn = 0;
        repeat (8) step();
        chk("glitch_mode", 32'(bus.view_mode), 32'h0);

        press_seq();
        chk("br1_mode", 32'(bus.view_mode),    32'h1);
        chk("br1_off",  32'(bus.view_offset),  32'h1);
        chk("br1_disp", 32'(bus.display_byte), 32'h05);
        press_seq();
        chk("br2_disp", 32'(bus.display_byte), 32'h04);
        press_seq();
        chk("br3_disp", 32'(bus.display_byte), 32'h03);
        press_seq();
        chk("br4_mode", 32'(bus.view_mode),    32'h0);
        chk("br4_disp", 32'(bus.display_byte), 32'h06);

        // Pinned entry follows captures
        press_seq();
        chk("pin_disp0", 32'(bus.display_byte), 32'h05);
        strobe(1, 32'h07, 0, 32'h0);
        chk("pin_off", 32'(bus.view_offset), 32'h2);
        step();
        chk("pin_disp1", 32'(bus.display_byte), 32'h05);
        strobe(1, 32'h08, 1, 32'h09);
        chk("pin_live", 32'(bus.view_mode),   32'h0);
        chk("pin_off0", 32'(bus.view_offset), 32'h0);
        step();
        chk("pin_newest", 32'(bus.display_byte), 32'h09);

        // Press coinciding with a capture, then timeout
        press_seq();
        chk("pc_disp0", 32'(bus.display_byte), 32'h08);
        for (int i = 1; i <= 16; i++) begin
            bus.btn = (i <= 8);
            bus.sample_en = (i == 7);
            bus.valid1 = (i == 7);
            bus.result1 = 32'h0A;
            step();
        end
        idle_in();
        chk("pc_off",  32'(bus.view_offset),  32'h3);
        chk("pc_disp", 32'(bus.display_byte), 32'h07);
        repeat (90) step();
        chk("tmo_hold", 32'(bus.view_mode), 32'h1);
        step();
        chk("tmo_mode", 32'(bus.view_mode),   32'h0);
        chk("tmo_off",  32'(bus.view_offset), 32'h0);

        // Zero result handling
        @(posedge clk); #1;
        reset_mid();
        strobe(1, 32'h0, 1, 32'h09);
        chk("zero_cnt", 32'(bus.entry_count), 32'(EXP6));
        step();
        chk("zero_disp", 32'(bus.display_byte), 32'h09);

        // Press with fewer than two entries is ignored
        @(posedge clk); #1;
        reset_mid();
        strobe(1, 32'h33, 0, 32'h0);
        press_seq();
        chk("few_mode", 32'(bus.view_mode),    32'h0);
        chk("few_disp", 32'(bus.display_byte), 32'h33);

        // Randomized traffic against the model
        hold = 0;
        btn_r = 0;
        for (int i = 0; i < 2500; i++) begin
            if (i == 1200) begin
                @(posedge clk); #1;
                reset_mid();
                btn_r = 0; hold = 0;
            end
            bus.sample_en = ($urandom_range(0, 3) == 0);
            bus.valid1 = $urandom_range(0, 1) == 1;
            bus.valid2 = $urandom_range(0, 1) == 1;
            bus.result1 = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            bus.result2 = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if (hold == 0) begin
                btn_r = ~btn_r;
                hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 150))
                                                   : int'($urandom_range(1, 10));
            end
            hold--;
            bus.btn = btn_r;
            step();
        end
        idle_in();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
